// File: rtl/mboot_pkg.sv
// Shared types and constants for the MBOOT reboot controller and its helpers.
// Holds the FSM state encoding, the status LED codes and the image address type.
package mboot_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        SETUP     = 3'd2,
        PULSE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    typedef logic [7:0] addr_t;

    localparam logic [2:0] LED_IDLE = 3'b001;
    localparam logic [2:0] LED_ARM  = 3'b010;
    localparam logic [2:0] LED_BOOT = 3'b100;
    localparam logic [2:0] LED_OFF  = 3'b000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debouncer and a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module key_debounce #(
    parameter int DEB_CYCLES = 240000
) (
    input  logic clk,
    input  logic srst,
    input  logic key_raw,
    output logic key_press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          press_reg;
    logic          sync_key;

    assign sync_key  = sync_reg[1];
    assign key_press = press_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], key_raw};
        end
    end

    // The counter only runs while the input disagrees with the accepted level,
    // so any bounce back to the old level restarts the stability window.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (sync_key != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync_key;
                    cnt_reg   <= '0;
                    press_reg <= ~sync_key;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/mboot_reboot_ctrl.sv
// Timed, cancellable reboot sequencer for EG_LOGIC_MBOOT in dynamic-address mode.
// Button presses reboot into DEFAULT_ADDR; the request port supplies its own address.
module mboot_reboot_ctrl
    import mboot_pkg::*;
#(
    parameter int          DEB_CYCLES   = 240000,
    parameter int          ARM_CYCLES   = 24000000,
    parameter int          SETUP_CYCLES = 4,
    parameter int          PULSE_CYCLES = 16,
    parameter logic [7:0]  DEFAULT_ADDR = 8'h0A
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       keyB,
    input  logic       req_valid,
    input  logic [7:0] req_addr,
    output logic       req_ready,
    input  logic       abort,
    output logic [7:0] dynamic_addr,
    output logic       rebootn,
    output logic       busy,
    output logic [2:0] RGB_LED
);

    localparam int MAX_AS = (ARM_CYCLES > SETUP_CYCLES) ? ARM_CYCLES : SETUP_CYCLES;
    localparam int PMAX   = ((MAX_AS > PULSE_CYCLES) ? MAX_AS : PULSE_CYCLES) - 1;
    localparam int PW     = (PMAX > 0) ? $clog2(PMAX + 1) : 1;

    localparam int BLINK_PERIOD = (ARM_CYCLES / 8 > 0) ? ARM_CYCLES / 8 : 1;
    localparam int BW           = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [PW-1:0] ARM_LAST   = PW'(ARM_CYCLES - 1);
    localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [PW-1:0] phase_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_reg;
    addr_t         addr_reg;
    logic          key_press;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk       (CLK_IN),
        .srst      (RST),
        .key_raw   (keyB),
        .key_press (key_press)
    );

    // State register plus the phase/blink counters and the latched image address.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            addr_reg      <= DEFAULT_ADDR;
        end else begin
            state_reg <= state_next;

            if (state_next != state_reg) begin
                phase_reg <= '0;
            end else if (state_reg == COUNTDOWN || state_reg == SETUP || state_reg == PULSE) begin
                phase_reg <= phase_reg + PW'(1);
            end

            if (state_reg == COUNTDOWN && state_next == COUNTDOWN) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_reg <= '0;
                    blink_reg     <= ~blink_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BW'(1);
                end
            end else begin
                blink_cnt_reg <= '0;
                blink_reg     <= 1'b0;
            end

            // A coincident key press is dropped in favour of the explicit request.
            if (state_reg == IDLE && state_next == COUNTDOWN) begin
                addr_reg <= req_valid ? req_addr : DEFAULT_ADDR;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid || key_press) begin
                    state_next = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (abort || key_press) begin
                    state_next = IDLE;
                end else if (phase_reg == ARM_LAST) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (phase_reg == SETUP_LAST) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (phase_reg == PULSE_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = (state_reg == IDLE);
        busy         = (state_reg != IDLE);
        rebootn      = (state_reg != PULSE);
        dynamic_addr = addr_reg;
        case (state_reg)
            IDLE:      RGB_LED = LED_IDLE;
            COUNTDOWN: RGB_LED = blink_reg ? LED_OFF : LED_ARM;
            default:   RGB_LED = LED_BOOT;
        endcase
    end

endmodule
